pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 147 ++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer: holds the PLL in reset, waits for a synchronised lock, checks that the
// lock stays stable, then releases the system reset. After repeated failures it falls back to bypass.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic       referenceclk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_reset,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam logic [15:0] HOLD_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAILED
    } state_t;

    typedef struct packed {
        logic pll_resetb;
        logic pll_bypass;
        logic sys_reset;
        logic locked;
        logic fail;
    } drive_t;

    function automatic drive_t decode(input state_t s);
        drive_t d;
        d = '{pll_resetb: 1'b0, pll_bypass: 1'b0, sys_reset: 1'b1, locked: 1'b0, fail: 1'b0};
        case (s)
            S_HOLD:      d.pll_resetb = 1'b0;
            S_WAIT_LOCK: d.pll_resetb = 1'b1;
            S_STABLE:    d.pll_resetb = 1'b1;
            S_RUN: begin
                d.pll_resetb = 1'b1;
                d.sys_reset  = 1'b0;
                d.locked     = 1'b1;
            end
            S_FAILED: begin
                d.pll_bypass = 1'b1;
                d.sys_reset  = 1'b0;
                d.fail       = 1'b1;
            end
            default:     d.pll_resetb = 1'b0;
        endcase
        return d;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [3:0]  retry_next;
    logic [3:0]  retry_inc;
    logic        attempt_fail;
    logic        counting;
    logic        lock_meta;
    logic        lock_sync;

    // PLL_LOCK is asynchronous to the reference clock; two flops before anything decodes it.
    always_ff @(posedge referenceclk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    assign retry_inc = retry_cnt + 4'd1;
    assign counting  = (state == S_HOLD) || (state == S_WAIT_LOCK) || (state == S_STABLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_next   = state;
        retry_next   = retry_cnt;
        attempt_fail = 1'b0;
        if (restart) begin
            state_next = S_HOLD;
            retry_next = 4'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle still counts as success.
                    if (lock_sync)                state_next   = S_STABLE;
                    else if (cnt == TIMEOUT_LAST) attempt_fail = 1'b1;
                end
                S_STABLE: begin
                    if (!lock_sync) begin
                        attempt_fail = 1'b1;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = S_RUN;
                        retry_next = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!lock_sync) begin
                        state_next = S_HOLD;
                        retry_next = 4'd0;
                    end
                end
                S_FAILED: state_next = S_FAILED;
                default:  state_next = S_HOLD;
            endcase
            if (attempt_fail) begin
                retry_next = retry_inc;
                state_next = (retry_inc == RETRY_LIMIT) ? S_FAILED : S_HOLD;
            end
        end
    end

    always_ff @(posedge referenceclk or posedge reset) begin
        if (reset) begin
            state     <= S_HOLD;
            cnt       <= 16'd0;
            retry_cnt <= 4'd0;
            {pll_resetb, pll_bypass, sys_reset, locked, fail} <= decode(S_HOLD);
        end else begin
            // NOTE: non-blocking throughout so every flop samples the pre-edge values.
            state     <= state_next;
            retry_cnt <= retry_next;
            if (restart || (state_next != state)) cnt <= 16'd0;
            else if (counting)                    cnt <= cnt + 16'd1;
            // Outputs are decoded from the next state so they change on the same edge as the state.
            {pll_resetb, pll_bypass, sys_reset, locked, fail} <= decode(state_next);
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Randomised bench for pll_lock_ctrl: a phase/elapsed-time reference model predicts every cycle,
// expectations are queued at stimulus time and a monitor compares them against the DUT.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 3;
    localparam int NUM_SEGMENTS  = 45;

    typedef struct packed {
        logic       pll_resetb;
        logic       pll_bypass;
        logic       sys_reset;
        logic       locked;
        logic       fail;
        logic [3:0] retry_cnt;
    } obs_t;

    localparam obs_t RESET_OBS = '{pll_resetb: 1'b0, pll_bypass: 1'b0, sys_reset: 1'b1,
                                   locked: 1'b0, fail: 1'b0, retry_cnt: 4'd0};

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       restart;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_reset;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .referenceclk(clk),
        .reset       (rst),
        .pll_lock    (pll_lock),
        .restart     (restart),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t exp_q[$];

    task automatic check(input string name, input obs_t act, input obs_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got resetb/bypass/sysrst/locked/fail/retry=%b required %b",
                     name, $time, act, req);
        end
    endtask

    function automatic obs_t dut_obs();
        return '{pll_resetb: pll_resetb, pll_bypass: pll_bypass, sys_reset: sys_reset,
                 locked: locked, fail: fail, retry_cnt: retry_cnt};
    endfunction

    // Reference model: which phase we are in, how many cycles it has lasted, failed attempts so far.
    typedef enum int {PH_HOLD, PH_WAIT, PH_STABLE, PH_RUN, PH_FAILED} phase_t;
    phase_t phase;
    int     elapsed;
    int     retries;
    bit     raw_hist[$];

    task automatic model_reset();
        phase    = PH_HOLD;
        elapsed  = 0;
        retries  = 0;
        raw_hist = '{1'b0, 1'b0};
    endtask

    task automatic model_attempt_failed();
        retries++;
        elapsed = 0;
        phase   = (retries == MAX_RETRY) ? PH_FAILED : PH_HOLD;
    endtask

    // One rising edge: raw lock sampled now, the controller acts on the value from two edges ago.
    task automatic model_step(input bit raw_now, input bit rs);
        bit seen;
        raw_hist.push_back(raw_now);
        seen = raw_hist[0];
        void'(raw_hist.pop_front());
        if (rs) begin
            phase   = PH_HOLD;
            elapsed = 0;
            retries = 0;
            return;
        end
        case (phase)
            PH_HOLD: begin
                elapsed++;
                if (elapsed == RST_CYCLES) begin
                    phase   = PH_WAIT;
                    elapsed = 0;
                end
            end
            PH_WAIT: begin
                if (seen) begin
                    phase   = PH_STABLE;
                    elapsed = 0;
                end else begin
                    elapsed++;
                    if (elapsed == LOCK_TIMEOUT) model_attempt_failed();
                end
            end
            PH_STABLE: begin
                if (!seen) begin
                    model_attempt_failed();
                end else begin
                    elapsed++;
                    if (elapsed == STABLE_CYCLES) begin
                        phase   = PH_RUN;
                        elapsed = 0;
                        retries = 0;
                    end
                end
            end
            PH_RUN: begin
                if (!seen) begin
                    phase   = PH_HOLD;
                    elapsed = 0;
                    retries = 0;
                end
            end
            default: ;
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o = RESET_OBS;
        case (phase)
            PH_WAIT, PH_STABLE: o.pll_resetb = 1'b1;
            PH_RUN: begin
                o.pll_resetb = 1'b1;
                o.sys_reset  = 1'b0;
                o.locked     = 1'b1;
            end
            PH_FAILED: begin
                o.pll_bypass = 1'b1;
                o.sys_reset  = 1'b0;
                o.fail       = 1'b1;
            end
            default: ;
        endcase
        o.retry_cnt = 4'(retries);
        return o;
    endfunction

    // Drives one cycle of stimulus; optionally pulses reset between edges and checks its immediate effect.
    task automatic drive_cycle(input bit lock_val, input bit rs, input bit pulse_rst);
        @(negedge clk);
        rst      = 1'b0;
        pll_lock = lock_val;
        restart  = rs;
        if (pulse_rst) begin
            #1 rst = 1'b1;
            #1 check("async_reset", dut_obs(), RESET_OBS);
            model_reset();
            #1 rst = 1'b0;
        end
        model_step(lock_val, rs);
        exp_q.push_back(model_obs());
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_obs(), e);
            end
        end
    end

    initial begin : stimulus
        int mode;
        int len;
        int rise;
        bit lv;
        bit rs;
        bit pr;
        rst      = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        model_reset();
        #2 check("reset_state", dut_obs(), RESET_OBS);
        repeat (2) begin
            @(negedge clk);
            exp_q.push_back(model_obs());
        end

        // Clean start: lock appears a few cycles after release and stays up into RUN.
        for (int c = 0; c < 60; c++) drive_cycle(c >= 10, 1'b0, 1'b0);
        // Lock held low: three timeouts and the fall-back to bypass.
        for (int c = 0; c < 120; c++) drive_cycle(1'b0, 1'b0, 1'b0);
        // Restart out of FAILED, then a clean relock.
        drive_cycle(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 60; c++) drive_cycle(c >= 3, 1'b0, 1'b0);
        // Drop lock in RUN, then relock.
        for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 60; c++) drive_cycle(1'b1, 1'b0, 1'b0);

        for (int s = 0; s < NUM_SEGMENTS; s++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(60, 300);
            rise = $urandom_range(0, 30);
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0:       lv = (c >= rise) && ($urandom_range(0, 299) != 0);
                    1:       lv = 1'b0;
                    default: lv = ($urandom_range(0, 9) != 0);
                endcase
                rs = ($urandom_range(0, 249) == 0);
                if (c == 0 && phase == PH_FAILED && $urandom_range(0, 1) == 1) rs = 1'b1;
                // Aim restarts at the exact timeout edge to exercise that collision.
                if (phase == PH_WAIT && elapsed == LOCK_TIMEOUT - 1 && raw_hist[0] == 1'b0
                    && $urandom_range(0, 2) == 0) rs = 1'b1;
                pr = ($urandom_range(0, 399) == 0);
                if (phase == PH_STABLE && $urandom_range(0, 19) == 0) pr = 1'b1;
                drive_cycle(lv, rs, pr);
            end
        end

        @(negedge clk);
        restart = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
